ahb3lite_sram_slave: RTL and testbench
======================================

Name: ahb3lite_sram_slave

Overview:
- AHB-Lite single-slave SRAM model that sits directly downstream of the bench master interface.
- Consumes address/control/write-data phases driven by the master and returns read data, ready and response.
- Used as the DUT-side target for the design-verification and emulation environment; implements configurable wait states and the two-cycle ERROR response.

Parameters:
- MEM_WORDS, 1024, memory depth in 32-bit words; legal byte addresses 0 .. 4*MEM_WORDS-1
- WAIT_STATES, 0, wait cycles inserted in every OKAY data phase (0..15)

Ports:
- HCLK  input  1  clock, rising edge
- HRESET  input  1  asynchronous active-high reset
- i_HSEL  input  1  slave select
- i_HADDR  input  32  byte address
- i_HWRITE  input  1  1 = write, 0 = read
- i_HTRANS  input  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
- i_HSIZE  input  3  000 byte, 001 halfword, 010 word
- i_HBURST  input  3  burst type (used only with the optional feature)
- i_HWDATA  input  32  write data, valid in the data phase
- o_HRDATA  output  32  read data
- o_HREADY  output  1  transfer done / slave ready
- o_HRESP  output  1  0 OKAY, 1 ERROR

Behaviour:
- Clocking and reset: one clock HCLK; HRESET is asynchronous, active-high.
- Reset values: o_HREADY=1, o_HRESP=0, o_HRDATA=0, FSM=IDLE, wait counter=0, pending-write flag=0. Memory contents are not cleared.
- Address-phase sampling: address, control and select are registered on the HCLK edge where o_HREADY=1. Transfer is active when i_HSEL=1 and i_HTRANS is NONSEQ or SEQ.
- IDLE/BUSY/unselected: zero-wait OKAY data phase; no memory access; o_HRDATA holds its last value.
- Error check on the active address phase (any one triggers ERROR):
  - i_HSIZE > 010
  - misaligned: halfword with addr[0]=1, or word with addr[1:0]≠00
  - addr ≥ 4*MEM_WORDS
- FSM states:
  - IDLE: no data phase pending.
  - WAIT: o_HREADY=0; counter counts WAIT_STATES down to 1, then goes to DATA.
  - DATA: o_HREADY=1, o_HRESP=0. Reads present data this cycle; writes commit at the end of this cycle.
  - ERR1: o_HREADY=0, o_HRESP=1.
  - ERR2: o_HREADY=1, o_HRESP=1.
- FSM transitions:
  - Active, legal transfer → WAIT if WAIT_STATES>0, else DATA.
  - Active, illegal transfer → ERR1 → ERR2.
  - From DATA or ERR2, a new address phase sampled on the same edge re-enters the flow (back-to-back pipelining).
- Latency: OKAY data phase lasts WAIT_STATES+1 cycles; ERROR lasts exactly 2 cycles.
- Write:
  - Byte lanes follow addr[1:0] and HSIZE (little-endian); only enabled lanes are written.
  - i_HWDATA is sampled on the edge that ends the data phase.
  - Errored transfers never write.
- Read:
  - o_HRDATA returns the full aligned 32-bit word.
  - A read whose address phase overlaps the preceding write's data phase to the same word returns the newly written lanes (write-to-read bypass).
- Address phase during ERR1: ignored. The master is required to drive IDLE; the bench checks this.
- Reset mid-transfer: FSM returns to IDLE immediately; pending write is dropped; the partially waited read is abandoned.

Optional Feature:
- Macro: AHB_BURST_CHECK_EN.
- Defined:
  - Each SEQ address is checked against the expected next address: previous + (1<<HSIZE), wrapping at the 4/8/16-beat boundary for WRAP bursts.
  - SEQ is also checked for HBURST/HSIZE/HWRITE equal to the burst's NONSEQ beat, and for crossing a 1 KB boundary in INCR bursts.
  - Any mismatch produces the two-cycle ERROR, and that beat is not written.
  - BUSY inside a burst does not advance the expected address.
- Not defined: i_HBURST is ignored and SEQ is treated exactly like NONSEQ.

Test Plan:
- WAIT_STATES=0: write word 0xDEADBEEF @0x10, then read @0x10 → read data phase 1 cycle, o_HRDATA=0xDEADBEEF, o_HRESP=0.
- Byte writes: 0xAA @0x21, halfword 0x1234 @0x22, then word read @0x20 → 0x1234AA00, starting from memory word 0x00000000.
- WAIT_STATES=3: read @0x40 → o_HREADY low 3 cycles, high on the 4th; back-to-back write→read same word → bypass data returned.
- Illegal accesses: word @0x02, then addr 0x1000 with MEM_WORDS=1024 → each gives ERR1 (HREADY=0, HRESP=1) then ERR2 (HREADY=1, HRESP=1); memory unchanged.
- HRESET asserted during the 2nd wait cycle of a write @0x80 → outputs immediately at reset values; later read @0x80 returns the old contents.
- AHB_BURST_CHECK_EN, WRAP4 word burst @0x38: 0x38, 0x3C, 0x30, 0x34 → all OKAY; a SEQ to 0x40 instead of 0x30 → ERROR on that beat.

Source files
------------

// File: rtl/ahb3lite_sram_slave.sv
// AHB-Lite SRAM slave: configurable OKAY wait states, two-cycle ERROR response, byte-lane writes.
// Optional macro AHB_BURST_CHECK_EN enables SEQ-beat address/control checking against the burst.

module ahb3lite_sram_slave #(
    parameter int MEM_WORDS   = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        i_HSEL,
    input  logic [31:0] i_HADDR,
    input  logic        i_HWRITE,
    input  logic [1:0]  i_HTRANS,
    input  logic [2:0]  i_HSIZE,
    input  logic [2:0]  i_HBURST,
    input  logic [31:0] i_HWDATA,
    output logic [31:0] o_HRDATA,
    output logic        o_HREADY,
    output logic        o_HRESP
);

    localparam int          AW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) << 2;
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t        state, state_n;
    logic [3:0]    wait_cnt;
    logic          wr_pending;
    logic          rd_pending;
    logic [AW-1:0] word_q;
    logic [3:0]    lanes_q;
    logic [31:0]   rdata_hold;
    logic [31:0]   mem [MEM_WORDS];

    logic          active;
    logic          illegal;
    logic          size_err;
    logic          align_err;
    logic          range_err;
    logic          seq_err;
    logic [3:0]    lanes;

    assign active = i_HSEL && i_HTRANS[1];

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        size_err  = i_HSIZE > 3'b010;
        align_err = ((i_HSIZE == 3'b001) && i_HADDR[0]) ||
                    ((i_HSIZE == 3'b010) && (i_HADDR[1:0] != 2'b00));
        range_err = {1'b0, i_HADDR} >= MEM_BYTES;
        case (i_HSIZE)
            3'b000:  lanes = 4'b0001 << i_HADDR[1:0];
            3'b001:  lanes = 4'b0011 << {i_HADDR[1], 1'b0};
            default: lanes = 4'b1111;
        endcase
    end

`ifdef AHB_BURST_CHECK_EN
    localparam logic [1:0] TR_BUSY   = 2'b01;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    logic        in_burst;
    logic        b_write;
    logic [2:0]  b_burst;
    logic [2:0]  b_size;
    logic [31:0] b_addr;
    logic [31:0] step;
    logic [31:0] wrap_mask;
    logic [31:0] exp_addr;
    logic [4:0]  beats;

    // Expected next beat: previous address plus transfer size, folded into the wrap window for WRAPx.
    always_comb begin
        step  = 32'd1 << b_size;
        beats = 5'd0;
        case (b_burst)
            3'b010:  beats = 5'd4;
            3'b100:  beats = 5'd8;
            3'b110:  beats = 5'd16;
            default: beats = 5'd0;
        endcase
        wrap_mask = ({27'd0, beats} << b_size) - 32'd1;
        if (beats != 5'd0)
            exp_addr = (b_addr & ~wrap_mask) | ((b_addr + step) & wrap_mask);
        else
            exp_addr = b_addr + step;
        seq_err = i_HSEL && (i_HTRANS == TR_SEQ) &&
                  (!in_burst || (i_HADDR != exp_addr) || (i_HBURST != b_burst) ||
                   (i_HSIZE != b_size) || (i_HWRITE != b_write) ||
                   (b_burst[0] && (exp_addr[31:10] != b_addr[31:10])));
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            in_burst <= 1'b0;
            b_addr   <= '0;
            b_burst  <= '0;
            b_size   <= '0;
            b_write  <= 1'b0;
        end else if (o_HREADY) begin
            if (i_HSEL && (i_HTRANS == TR_NONSEQ)) begin
                in_burst <= 1'b1;
                b_addr   <= i_HADDR;
                b_burst  <= i_HBURST;
                b_size   <= i_HSIZE;
                b_write  <= i_HWRITE;
            end else if (i_HSEL && (i_HTRANS == TR_SEQ)) begin
                b_addr <= i_HADDR;
            end else if (!(i_HSEL && (i_HTRANS == TR_BUSY))) begin
                in_burst <= 1'b0;
            end
        end
    end
`else
    logic unused_ok;
    assign unused_ok = ^{i_HBURST, i_HTRANS[0]};
    assign seq_err   = 1'b0;
`endif

    assign illegal = size_err || align_err || range_err || seq_err;

    always_comb begin
        state_n  = state;
        o_HREADY = 1'b1;
        o_HRESP  = 1'b0;
        case (state)
            S_IDLE, S_DATA, S_ERR2: begin
                o_HRESP = (state == S_ERR2);
                if (!active)
                    state_n = S_IDLE;
                else if (illegal)
                    state_n = S_ERR1;
                else if (WAIT_STATES > 0)
                    state_n = S_WAIT;
                else
                    state_n = S_DATA;
            end
            S_WAIT: begin
                o_HREADY = 1'b0;
                if (wait_cnt <= 4'd1)
                    state_n = S_DATA;
            end
            S_ERR1: begin
                o_HREADY = 1'b0;
                o_HRESP  = 1'b1;
                state_n  = S_ERR2;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state      <= S_IDLE;
            wait_cnt   <= 4'd0;
            wr_pending <= 1'b0;
            rd_pending <= 1'b0;
            word_q     <= '0;
            lanes_q    <= 4'd0;
            rdata_hold <= 32'd0;
        end else begin
            state <= state_n;
            if (state_n == S_WAIT)
                wait_cnt <= (state == S_WAIT) ? wait_cnt - 4'd1 : WAIT_INIT;
            if ((state == S_DATA) && rd_pending)
                rdata_hold <= mem[word_q];
            if (o_HREADY) begin
                wr_pending <= active && !illegal && i_HWRITE;
                rd_pending <= active && !illegal && !i_HWRITE;
                word_q     <= i_HADDR[AW+1:2];
                lanes_q    <= lanes;
            end
        end
    end

    // NOTE: the array has no reset; contents survive HRESET and map onto plain SRAM.
    always_ff @(posedge HCLK) begin
        if ((state == S_DATA) && wr_pending) begin
            for (int i = 0; i < 4; i++) begin
                if (lanes_q[i])
                    mem[word_q][8*i +: 8] <= i_HWDATA[8*i +: 8];
            end
        end
    end

    // A write commits on the edge that samples the next read's address, so the array read is already bypassed.
    assign o_HRDATA = ((state == S_DATA) && rd_pending) ? mem[word_q] : rdata_hold;

endmodule

// File: tb/tb_ahb3lite_sram_slave.sv
// Bench for ahb3lite_sram_slave: two instances (0 and 3 wait states), transaction model plus per-cycle compare.
// Build with AHB_BURST_CHECK_EN defined to add the WRAP4 burst-check scenario.

module tb_ahb3lite_sram_slave;

    localparam int         MEMW   = 1024;
    localparam int         WS0    = 0;
    localparam int         WS1    = 3;
    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] BUSY   = 2'b01;
    localparam logic [1:0] NONSEQ = 2'b10;
    localparam logic [1:0] SEQ    = 2'b11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cur = 1'b0;
    logic        sel = 1'b0;
    logic [31:0] haddr = 32'd0;
    logic        hwrite = 1'b0;
    logic [1:0]  htrans = IDLE;
    logic [2:0]  hsize = 3'd0;
    logic [2:0]  hburst = 3'd0;
    logic [31:0] hwdata = 32'd0;
    logic        hsel0, hsel1;
    logic [31:0] hrdata0, hrdata1, rdata;
    logic        hready0, hready1, rdy;
    logic        hresp0, hresp1, resp;

    typedef struct {
        bit          err;
        bit          rd;
        logic [31:0] data;
        int          len;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    bit          fin;
    int          cyc = 0;
    logic [31:0] last_rd [2];
    logic [31:0] mm [2][64];
    int          ncmp = 0;
    int          nbad = 0;

    always #5 clk = ~clk;

    assign hsel0 = sel && !cur;
    assign hsel1 = sel && cur;
    assign rdy   = cur ? hready1 : hready0;
    assign resp  = cur ? hresp1  : hresp0;
    assign rdata = cur ? hrdata1 : hrdata0;

    ahb3lite_sram_slave #(.MEM_WORDS(MEMW), .WAIT_STATES(WS0)) dut0 (
        .HCLK(clk), .HRESET(rst), .i_HSEL(hsel0), .i_HADDR(haddr), .i_HWRITE(hwrite),
        .i_HTRANS(htrans), .i_HSIZE(hsize), .i_HBURST(hburst), .i_HWDATA(hwdata),
        .o_HRDATA(hrdata0), .o_HREADY(hready0), .o_HRESP(hresp0)
    );

    ahb3lite_sram_slave #(.MEM_WORDS(MEMW), .WAIT_STATES(WS1)) dut1 (
        .HCLK(clk), .HRESET(rst), .i_HSEL(hsel1), .i_HADDR(haddr), .i_HWRITE(hwrite),
        .i_HTRANS(htrans), .i_HSIZE(hsize), .i_HBURST(hburst), .i_HWDATA(hwdata),
        .o_HRDATA(hrdata1), .o_HREADY(hready1), .o_HRESP(hresp1)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        ncmp++;
        if (got !== want) begin
            nbad++;
            $display("FAIL %s: got %h, want %h (t=%0t, dut%0d)", name, got, want, $time, cur);
        end
    endtask

    // Each queued item is one data phase: OKAY lasts WS+1 cycles with HREADY only in the last, ERROR lasts 2.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            cyc = 0;
            last_rd[0] = 32'd0;
            last_rd[1] = 32'd0;
        end else if (q.size() == 0) begin
            check("idle_hready", 32'(rdy), 32'd1);
            check("idle_hresp", 32'(resp), 32'd0);
            check("idle_hrdata_hold", rdata, last_rd[cur]);
        end else begin
            e   = q[0];
            fin = (cyc == e.len - 1);
            check("dp_hready", 32'(rdy), 32'(fin));
            check("dp_hresp", 32'(resp), 32'(e.err));
            if (e.err && cyc == 0)
                check("err1_master_idle", 32'(sel && htrans[1]), 32'd0);
            if (fin && e.rd) begin
                check("dp_hrdata", rdata, e.data);
                last_rd[cur] = e.data;
            end
            if (fin) begin
                void'(q.pop_front());
                cyc = 0;
            end else begin
                cyc++;
            end
        end
    end

    task automatic wait_accept();
        bit r;
        int n;
        n = 0;
        do begin
            @(negedge clk);
            r = rdy;
            @(posedge clk);
            n++;
        end while (!r && n < 64);
        check("accept_within_budget", 32'(r), 32'd1);
        #1;
    endtask

    task automatic xfer(input bit s, input logic [1:0] tr, input bit wr, input logic [31:0] a,
                        input logic [2:0] sz, input logic [2:0] bu, input logic [31:0] wd,
                        input bit ferr);
        bit   err;
        int   idx;
        int   l;
        exp_t x;
        sel    = s;
        htrans = tr;
        hwrite = wr;
        haddr  = a;
        hsize  = sz;
        hburst = bu;
        wait_accept();
        hwdata = wd;
        if (s && tr[1]) begin
            err = ferr || (sz > 3'd2) || (sz == 3'd1 && a[0]) || (sz == 3'd2 && a[1:0] != 2'b00) ||
                  (a >= 32'(4 * MEMW));
            idx = int'(a[7:2]);
            if (!err && wr) begin
                for (int b = 0; b < (1 << sz); b++) begin
                    l = int'(a[1:0]) + b;
                    mm[cur][idx][8*l +: 8] = wd[8*l +: 8];
                end
            end
            x.err  = err;
            x.rd   = !wr && !err;
            x.data = mm[cur][idx];
            x.len  = err ? 2 : ((cur ? WS1 : WS0) + 1);
            q.push_back(x);
        end
    endtask

    task automatic idle();
        xfer(1'b0, IDLE, 1'b0, 32'd0, 3'd0, 3'd0, 32'd0, 1'b0);
    endtask

    task automatic rand_xfer();
        int          r;
        logic [2:0]  sz;
        logic [31:0] a;
        logic [1:0]  tr;
        bit          wr;
        r  = $urandom_range(0, 99);
        wr = 1'($urandom_range(0, 1));
`ifdef AHB_BURST_CHECK_EN
        tr = NONSEQ;
`else
        tr = ($urandom_range(0, 1) != 0) ? SEQ : NONSEQ;
`endif
        if (r < 5) begin
            xfer(1'b1, IDLE, wr, $urandom, 3'd2, 3'd0, $urandom, 1'b0);
        end else if (r < 10) begin
            xfer(1'b0, tr, wr, 32'($urandom_range(0, 255)) & 32'hFC, 3'd2, 3'd0, $urandom, 1'b0);
        end else if (r < 15) begin
            xfer(1'b1, BUSY, wr, 32'($urandom_range(0, 255)) & 32'hFC, 3'd2, 3'd0, $urandom, 1'b0);
        end else if (r < 27) begin
            case ($urandom_range(0, 3))
                0: begin sz = 3'($urandom_range(3, 7)); a = 32'($urandom_range(0, 255)) & 32'hFC; end
                1: begin sz = 3'd1; a = 32'($urandom_range(0, 255)) | 32'h1; end
                2: begin sz = 3'd2; a = (32'($urandom_range(0, 255)) & 32'hFC) | 32'($urandom_range(1, 3)); end
                default: begin sz = 3'd2; a = 32'h1000 + (32'($urandom_range(0, 1 << 20)) << 2); end
            endcase
            xfer(1'b1, tr, wr, a, sz, 3'd0, $urandom, 1'b0);
            idle();
        end else begin
            sz = 3'($urandom_range(0, 2));
            a  = 32'($urandom_range(0, 255)) & ~((32'd1 << sz) - 32'd1);
            xfer(1'b1, tr, wr, a, sz, 3'd0, $urandom, 1'b0);
        end
    endtask

    task automatic init_mem();
        for (int i = 0; i < 64; i++)
            xfer(1'b1, NONSEQ, 1'b1, 32'(i * 4), 3'd2, 3'd0, 32'd0, 1'b0);
        idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_hready0", 32'(hready0), 32'd1);
        check("rst_hresp0", 32'(hresp0), 32'd0);
        check("rst_hrdata0", hrdata0, 32'd0);
        check("rst_hready1", 32'(hready1), 32'd1);
        check("rst_hresp1", 32'(hresp1), 32'd0);
        check("rst_hrdata1", hrdata1, 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;

        // Instance with zero wait states.
        cur = 1'b0;
        init_mem();
        xfer(1'b1, NONSEQ, 1'b1, 32'h10, 3'd2, 3'd0, 32'hDEADBEEF, 1'b0);
        xfer(1'b1, NONSEQ, 1'b0, 32'h10, 3'd2, 3'd0, 32'd0, 1'b0);
        idle();
        check("model_word_0x10", mm[0][4], 32'hDEADBEEF);

        xfer(1'b1, NONSEQ, 1'b1, 32'h21, 3'd0, 3'd0, 32'hAAAAAAAA, 1'b0);
        xfer(1'b1, NONSEQ, 1'b1, 32'h22, 3'd1, 3'd0, 32'h12341234, 1'b0);
        xfer(1'b1, NONSEQ, 1'b0, 32'h20, 3'd2, 3'd0, 32'd0, 1'b0);
        idle();
        check("model_word_0x20", mm[0][8], 32'h1234AA00);

        xfer(1'b1, NONSEQ, 1'b1, 32'h02, 3'd2, 3'd0, 32'hFFFFFFFF, 1'b0);
        idle();
        xfer(1'b1, NONSEQ, 1'b1, 32'h1000, 3'd2, 3'd0, 32'hFFFFFFFF, 1'b0);
        idle();
        xfer(1'b1, NONSEQ, 1'b0, 32'h00, 3'd2, 3'd0, 32'd0, 1'b0);
        idle();
        check("model_word_0x00", mm[0][0], 32'h00000000);

`ifdef AHB_BURST_CHECK_EN
        xfer(1'b1, NONSEQ, 1'b1, 32'h38, 3'd2, 3'b010, 32'h11110000, 1'b0);
        xfer(1'b1, SEQ,    1'b1, 32'h3C, 3'd2, 3'b010, 32'h22220000, 1'b0);
        xfer(1'b1, SEQ,    1'b1, 32'h30, 3'd2, 3'b010, 32'h33330000, 1'b0);
        xfer(1'b1, SEQ,    1'b1, 32'h34, 3'd2, 3'b010, 32'h44440000, 1'b0);
        xfer(1'b1, NONSEQ, 1'b1, 32'h38, 3'd2, 3'b010, 32'h55550000, 1'b0);
        xfer(1'b1, SEQ,    1'b1, 32'h3C, 3'd2, 3'b010, 32'h66660000, 1'b0);
        // The wrap window is 0x30..0x3F, so the third beat must be 0x30; 0x40 is an error.
        xfer(1'b1, SEQ,    1'b1, 32'h40, 3'd2, 3'b010, 32'hBADBAD00, 1'b1);
        idle();
        xfer(1'b1, NONSEQ, 1'b0, 32'h30, 3'd2, 3'd0, 32'd0, 1'b0);
        xfer(1'b1, NONSEQ, 1'b0, 32'h38, 3'd2, 3'd0, 32'd0, 1'b0);
        xfer(1'b1, NONSEQ, 1'b0, 32'h40, 3'd2, 3'd0, 32'd0, 1'b0);
        idle();
        check("model_word_0x30", mm[0][12], 32'h33330000);
        check("model_word_0x40", mm[0][16], 32'h00000000);
`endif

        repeat (200) rand_xfer();
        idle();

        // Instance with three wait states.
        cur = 1'b1;
        init_mem();
        xfer(1'b1, NONSEQ, 1'b0, 32'h40, 3'd2, 3'd0, 32'd0, 1'b0);
        xfer(1'b1, NONSEQ, 1'b1, 32'h44, 3'd2, 3'd0, 32'hCAFEF00D, 1'b0);
        xfer(1'b1, NONSEQ, 1'b0, 32'h44, 3'd2, 3'd0, 32'd0, 1'b0);
        idle();

        xfer(1'b1, NONSEQ, 1'b1, 32'h80, 3'd2, 3'd0, 32'h11223344, 1'b0);
        idle();
        sel    = 1'b1;
        htrans = NONSEQ;
        hwrite = 1'b1;
        haddr  = 32'h80;
        hsize  = 3'd2;
        wait_accept();
        hwdata = 32'h55667788;
        sel    = 1'b0;
        htrans = IDLE;
        e.err  = 1'b0;
        e.rd   = 1'b0;
        e.data = 32'd0;
        e.len  = WS1 + 1;
        q.push_back(e);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("midrst_hready", 32'(hready1), 32'd1);
        check("midrst_hresp", 32'(hresp1), 32'd0);
        check("midrst_hrdata", hrdata1, 32'd0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        xfer(1'b1, NONSEQ, 1'b0, 32'h80, 3'd2, 3'd0, 32'd0, 1'b0);
        idle();
        check("model_word_0x80", mm[1][32], 32'h11223344);

        repeat (200) rand_xfer();
        idle();
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end

endmodule
